// File: rtl/launchpad_player.sv
// Playback reader for the LaunchPad recorder: fetches 4-bit note codes from the
// shared note memory and replays each one as a square wave on the piezo output.
module launchpad_player #(
    parameter int unsigned STEP_CYCLES = 16,
    parameter int unsigned ADDR_W      = 12
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Start,
    input  logic              Stop,
    input  logic [ADDR_W-1:0] Last_addr,
    input  logic [3:0]        Din,
    output logic [ADDR_W-1:0] Accout,
    output logic              CE,
    output logic              RW,
    output logic              Pout,
    output logic [3:0]        Note,
    output logic              Busy
);

    localparam int unsigned STEP_W   = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [3:0]  END_CODE = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_PLAY  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W-1:0]   addr_next;
    logic [ADDR_W-1:0]   last;
    logic [STEP_W-1:0]   step;
    logic [STEP_W-1:0]   step_next;
    logic [3:0]          tone;
    logic [3:0]          tone_next;
    logic [3:0]          half_m1;
    logic                is_rest;
    logic                tone_hit;
    logic                step_done;
    logic                start_ok;
    logic                in_play;
    logic [ADDR_W-1:0]   accout_next;
    logic                ce_next;
    logic                pout_next;
    logic                busy_next;

    // The block never writes the note memory.
    assign RW = 1'b1;

    assign start_ok  = (state == S_IDLE) && Start && !Stop;
    assign step_done = (step == STEP_W'(STEP_CYCLES - 1));

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; Stop overrides every other transition
    always_comb begin
        state_next = state;
        if (Stop) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (Start) state_next = S_FETCH;
                S_FETCH: state_next = S_WAIT;
                S_WAIT:  state_next = (Din == END_CODE) ? S_IDLE : S_PLAY;
                S_PLAY: begin
                    if (step_done) begin
                        state_next = (addr == last) ? S_IDLE : S_FETCH;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Output/datapath next values, registered below so every output is a flop
    always_comb begin
        addr_next   = addr;
        step_next   = '0;
        tone_next   = '0;
        pout_next   = 1'b0;
        is_rest     = (Note == 4'd0) || (Note >= 4'd13);
        half_m1     = 4'd13 - Note;
        tone_hit    = (tone == half_m1);
        in_play     = (state == S_PLAY) && (state_next == S_PLAY);

        if (start_ok) begin
            addr_next = '0;
        end else if ((state == S_PLAY) && (state_next == S_FETCH)) begin
            addr_next = addr + ADDR_W'(1);
        end

        // Counters restart on every PLAY entry; tone reloads at the half-period
        if (in_play) begin
            step_next = step + STEP_W'(1);
            tone_next = tone_hit ? 4'd0 : tone + 4'd1;
            if (is_rest) begin
                pout_next = 1'b0;
            end else begin
                pout_next = tone_hit ? ~Pout : Pout;
            end
        end

        ce_next     = (state_next == S_FETCH);
        busy_next   = (state_next != S_IDLE);
        accout_next = (state_next == S_IDLE) ? '0 : addr_next;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            addr   <= '0;
            last   <= '0;
            step   <= '0;
            tone   <= '0;
            Accout <= '0;
            CE     <= 1'b0;
            Pout   <= 1'b0;
            Note   <= 4'd0;
            Busy   <= 1'b0;
        end else begin
            addr   <= addr_next;
            step   <= step_next;
            tone   <= tone_next;
            Accout <= accout_next;
            CE     <= ce_next;
            Pout   <= pout_next;
            Busy   <= busy_next;
            if (start_ok) begin
                last <= Last_addr;
            end
            // Memory data is valid during WAIT; the end marker is captured too
            if ((state == S_WAIT) && !Stop) begin
                Note <= Din;
            end
        end
    end

endmodule

// File: doc/launchpad_player.md
# launchpad_player

Playback reader for the LaunchPad recorder. It reads the 4-bit note codes that LaunchPad stored in the external 4K x 4 note memory, using the same CE/RW/address bus convention. It then regenerates each note as a square wave on the piezo output for a fixed step time. It sits beside LaunchPad on the memory bus and owns the bus only while playing.

## Interface
- STEP_CYCLES, default 16: clocks each note, or rest, is played; minimum 2.
- ADDR_W, default 12: memory address width.
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- Start  in  1  level-sampled; begins playback from address 0 when idle.
- Stop  in  1  level-sampled; aborts playback.
- Last_addr  in  ADDR_W  last address to play; latched on accepted Start.
- Din  in  4  memory read data; valid the cycle after a CE read pulse.
- Accout  out  ADDR_W  memory address.
- CE  out  1  memory chip enable; one-cycle pulse per read.
- RW  out  1  1 = read; held 1 at all times because this block never writes.
- Pout  out  1  piezo square-wave output.
- Note  out  4  code currently playing.
- Busy  out  1  high whenever the FSM is not IDLE.

## Operation
- The FSM has four states: IDLE, FETCH, WAIT and PLAY.
- IDLE:
  - Outputs: CE=0, Pout=0, Busy=0, Accout=0.
  - Transition: Start=1 and Stop=0 goes to FETCH, latching Last_addr and setting the address counter to 0.
- FETCH:
  - Outputs: CE=1, RW=1, Accout = address counter.
  - Transition: always goes to WAIT.
- WAIT:
  - Outputs: CE=0.
  - Din is registered into Note at the end of this cycle.
  - Transition: Din=4'hF is the end marker and goes to IDLE with no PLAY. Any other code goes to PLAY.
- PLAY:
  - Lasts STEP_CYCLES cycles, counted by a step counter cleared on entry.
  - Transition when the step count expires: if address counter == latched Last_addr, go to IDLE. Otherwise increment the address and go to FETCH.
- Note decode:
  - Code 0, 13 or 14 is a rest: Pout=0 for the whole step.
  - Code n in 1..12 is a tone with a half-period of (14 - n) clocks. Code 1 gives 13 clocks; code 12 gives 2 clocks.
  - The tone counter is 4 bits and cleared on PLAY entry. Pout is 0 on PLAY entry and toggles each time the tone counter reaches half-period - 1. At that point the counter reloads to 0.
  - Pout is forced to 0 outside PLAY.
- Address:
  - The address counter is ADDR_W bits and never wraps, because playback ends at Last_addr.
  - With Last_addr = all-ones, the last read is at 12'hFFF.
- Stop:
  - From any state, goes to IDLE on the next edge.
  - CE=0, Pout=0 and Accout=0 from that edge onward.
  - Stop takes priority over Start and over every other transition.
- Start while Busy is ignored; it does not restart playback.
- Note keeps its last code in IDLE and resets to 0 only on RST.

## Timing
- Reset values, applied immediately on RST assertion with no clock needed:
  - Accout=0, CE=0, RW=1, Pout=0, Note=0, Busy=0.
  - FSM=IDLE, all counters 0.
- Start to first CE: Start sampled at edge k gives CE=1 and Accout=0 during cycle k+1.
- Per-note cycle cost:
  - FETCH 1 + WAIT 1 + PLAY STEP_CYCLES = STEP_CYCLES+2 clocks.
  - CE pulses are exactly STEP_CYCLES+2 clocks apart.
- Memory latency:
  - Din must be valid during the WAIT cycle, i.e. one cycle after CE.
  - Note updates on the edge ending WAIT.
- End marker: Busy falls on the edge after WAIT, 3 clocks after Start is sampled if 4'hF is at address 0.
- Last note: Busy falls on the edge ending the final PLAY cycle.
- RST mid-operation: immediate reset values; playback is not resumed on RST release.

## Test plan
- Reset with RST=1 for 400 ns at a 100 ns period:
  - Required during reset: Accout=0, CE=0, RW=1, Pout=0, Busy=0, Note=0.
  - Required after release: the block stays IDLE with Start=0.
- Memory [1, 0, 12, F], Last_addr=12'h00A, Start pulse:
  - CE pulses at Accout 0, 1, 2, 3, spaced 18 clocks apart.
  - Code 1: Pout toggles every 13 clocks.
  - Code 0: Pout stays 0.
  - Code 12: Pout toggles every 2 clocks.
  - After the 4'hF read, Busy falls with no fourth PLAY.
- Memory [3, 3, 3], Last_addr=12'h001:
  - Exactly two CE reads, at addresses 0 and 1.
  - Busy falls after the second PLAY.
  - Accout returns to 0.
- Stop=1 for one cycle in the middle of PLAY of code 5:
  - Next edge: Busy=0, Pout=0, CE=0.
  - Note holds 5.
  - No further CE pulses.
- Start held high through playback: no restart.
- Start and Stop asserted together in IDLE: the block stays IDLE with CE=0.
- RST asserted between clock edges during PLAY: all outputs take their reset values before the next CLK edge.
